// File: rtl/neopixel_stream.sv
// rtl/neopixel_stream.sv - WS2812-class serial LED driver fed by a valid/ready pixel stream
//
// Purpose: serialises NBR_PIXELS pixels per frame onto a single-wire LED strip,
// MSB first. Each bit is TBIT cycles, high for T1H (one) or T0H (zero) cycles.
// Every frame ends with a TRESET-cycle low latch gap. If a pixel is not
// delivered before the previous one finishes, the frame is aborted and
// underrun is pulsed.
//
// Ports:
//   clk_16MHz   in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   start_tx    in   frame request, only looked at in IDLE
//   pixel_data  in   next pixel (BITS_PER_PIXEL bits)
//   pixel_valid in   pixel_data valid
//   pixel_ready out  block accepts pixel_data this cycle
//   dout        out  registered serial output to the strip
//   busy        out  high whenever not IDLE
//   done        out  one-cycle pulse at frame completion
//   underrun    out  one-cycle pulse when a frame is aborted for lack of data

module neopixel_stream #(
  parameter int NBR_PIXELS     = 8,
  parameter int BITS_PER_PIXEL = 24,
  parameter int T0H            = 6,
  parameter int T1H            = 13,
  parameter int TBIT           = 20,
  parameter int TRESET         = 800
) (
  input  logic                      clk_16MHz,
  input  logic                      reset,
  input  logic                      start_tx,
  input  logic [BITS_PER_PIXEL-1:0] pixel_data,
  input  logic                      pixel_valid,
  output logic                      pixel_ready,
  output logic                      dout,
  output logic                      busy,
  output logic                      done,
  output logic                      underrun
);

  localparam int PIX_W = $clog2(NBR_PIXELS + 1);
  localparam int BIT_W = $clog2(TBIT);
  localparam int IDX_W = $clog2(BITS_PER_PIXEL);
  localparam int LAT_W = $clog2(TRESET + 1);

  localparam logic [PIX_W-1:0] PIX_INIT = PIX_W'(NBR_PIXELS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TBIT - 1);
  localparam logic [BIT_W-1:0] T0H_C    = BIT_W'(T0H);
  localparam logic [BIT_W-1:0] T1H_C    = BIT_W'(T1H);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_PER_PIXEL - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(TRESET - 1);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, SEND, LATCH} state_t;

  state_t                    state_q, state_d;
  logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
  logic [BITS_PER_PIXEL-1:0] buf_q, buf_d;
  logic                      buf_full_q, buf_full_d;
  logic [PIX_W-1:0]          req_cnt_q, req_cnt_d;   // pixels still to accept this frame
  logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;   // cycle within the current bit
  logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;   // bits already sent of the current pixel
  logic [LAT_W-1:0]          lat_cnt_q, lat_cnt_d;
  logic                      dout_q, dout_d;
  logic                      done_q, done_d;
  logic                      underrun_q, underrun_d;
  logic [BIT_W-1:0]          high_len;
  logic                      xfer;

  assign pixel_ready = ((state_q == WAIT_FIRST) || (state_q == SEND)) &&
                       !buf_full_q && (req_cnt_q != '0);
  assign xfer        = pixel_valid && pixel_ready;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    req_cnt_d  = req_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    lat_cnt_d  = lat_cnt_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_tx) begin
          state_d    = WAIT_FIRST;
          req_cnt_d  = PIX_INIT;
          buf_full_d = 1'b0;
        end
      end

      WAIT_FIRST: begin
        // First pixel bypasses the holding buffer.
        if (xfer) begin
          state_d   = SEND;
          shift_d   = pixel_data;
          req_cnt_d = req_cnt_q - PIX_W'(1);
          bit_cnt_d = '0;
          bit_idx_d = '0;
        end
      end

      SEND: begin
        if (xfer) begin
          req_cnt_d  = req_cnt_q - PIX_W'(1);
          buf_d      = pixel_data;
          buf_full_d = 1'b1;
        end
        if (bit_cnt_q != BIT_LAST) begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end else begin
          bit_cnt_d = '0;
          if (bit_idx_q != IDX_LAST) begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            shift_d   = {shift_q[BITS_PER_PIXEL-2:0], 1'b0};
          end else begin
            bit_idx_d = '0;
            if (buf_full_q) begin
              shift_d    = buf_q;
              buf_full_d = 1'b0;
            end else if (xfer) begin
              // Pixel arriving on the boundary edge is still in time and
              // goes straight to the shifter instead of the buffer.
              shift_d    = pixel_data;
              buf_full_d = 1'b0;
            end else begin
              state_d    = LATCH;
              lat_cnt_d  = '0;
              underrun_d = (req_cnt_q != '0);
            end
          end
        end
      end

      LATCH: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          buf_full_d = 1'b0;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // dout is registered, so it is derived from the state the next cycle
    // will be in; that makes each high phase exactly T0H/T1H cycles long.
    high_len = shift_d[BITS_PER_PIXEL-1] ? T1H_C : T0H_C;
    dout_d   = (state_d == SEND) && (bit_cnt_d < high_len);
  end

  always_ff @(posedge clk_16MHz) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      req_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      lat_cnt_q  <= '0;
      dout_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      req_cnt_q  <= req_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      lat_cnt_q  <= lat_cnt_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign dout     = dout_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule
